// File: rtl/fb_pixel_writer_pkg.sv
// Shared types for the framebuffer pixel writer: pixel coordinate, write-FSM
// state encoding, the pixel record and a clip-window helper.
package fb_pixel_writer_pkg;

  typedef struct packed {
    shortint x;
    shortint y;
  } Point2D;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR    = 2'd1,
    WRITE   = 2'd2,
    RECOVER = 2'd3
  } FbWrState;

  localparam int PIX_COLOR_W = 16;

  typedef struct packed {
    Point2D                 pt;
    logic [PIX_COLOR_W-1:0] color;
  } PixelWr;

  // True when the coordinate lies inside a w x h window anchored at (0,0).
  function automatic logic pt_in_window(input Point2D p, input int w, input int h);
    int px;
    int py;
    px = int'(p.x);
    py = int'(p.y);
    return (px >= 0) && (px < w) && (py >= 0) && (py < h);
  endfunction

endpackage

// File: rtl/fb_pixel_writer_pixel_fifo.sv
// pixel_fifo: synchronous FIFO with registered storage and a combinational
// head (the entry at the read pointer is visible without read latency).
// Pushes while full and pops while empty are ignored.
module pixel_fifo
  import fb_pixel_writer_pkg::*;
#(
  parameter int WIDTH = $bits(PixelWr),
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q[PTR_W-1:0]];

  // Next-pointer logic for accepted pushes and pops.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: buffers rasterizer pixels, converts each to a linear
// framebuffer address (y*H_RES + x) and runs a fixed-timing async SRAM write.
// Optional feature macro: FB_CLIP_EN (drop off-screen pixels, count them).
module fb_pixel_writer
  import fb_pixel_writer_pkg::*;
#(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int ADDR_W     = 19,
  parameter int COLOR_W    = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int WR_CYCLES  = 2
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  Point2D             in_pt,
  input  logic [COLOR_W-1:0] in_color,
  output logic [ADDR_W-1:0]  sram_addr,
  output logic [COLOR_W-1:0] sram_wdata,
  output logic               sram_we_n,
  output logic               sram_ce_n,
  output logic               busy,
  output logic [15:0]        clip_cnt
);

  localparam int ENTRY_W = $bits(Point2D) + COLOR_W;
  localparam int CNT_W   = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

  // Linear address computed at 32 bits, then truncated to the SRAM width.
  function automatic logic [ADDR_W-1:0] fb_addr(input Point2D p);
    logic signed [31:0] prod;
    prod = int'(p.y) * H_RES + int'(p.x);
    return ADDR_W'(prod);
  endfunction

  logic [ENTRY_W-1:0] fifo_wdata;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  Point2D             head_pt;
  logic [COLOR_W-1:0] head_color;

  logic               rdy_en_q, rdy_en_d;
  FbWrState           state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  Point2D             pt_q, pt_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic [ADDR_W-1:0]  sram_addr_q, sram_addr_d;
  logic [COLOR_W-1:0] sram_wdata_q, sram_wdata_d;
  logic               we_n_q, we_n_d;
  logic               ce_n_q, ce_n_d;
  logic               clipped;

  assign fifo_wdata             = {in_pt, in_color};
  assign {head_pt, head_color}  = fifo_rdata;
  assign in_ready               = rdy_en_q & ~fifo_full;
  assign fifo_push              = in_valid & in_ready;

  pixel_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef FB_CLIP_EN
  logic [15:0] clip_q, clip_d;

  assign clipped  = ~pt_in_window(pt_q, H_RES, V_RES);
  assign clip_cnt = clip_q;

  // Saturating count of pixels dropped in ADDR because they fall off-screen.
  always_comb begin
    clip_d = clip_q;
    if (state_q == ADDR && clipped && clip_q != 16'hFFFF) clip_d = clip_q + 16'd1;
  end

  // Clip counter register.
  always_ff @(posedge clk) begin
    if (!n_rst) clip_q <= '0;
    else        clip_q <= clip_d;
  end
`else
  assign clipped  = 1'b0;
  assign clip_cnt = '0;
`endif

  // in_ready is held low through reset and enabled one edge after release.
  always_comb begin
    rdy_en_d = 1'b1;
  end

  // Write sequencer next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pt_d         = pt_q;
    color_d      = color_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    we_n_d       = 1'b1;
    ce_n_d       = 1'b1;
    fifo_pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          pt_d     = head_pt;
          color_d  = head_color;
          state_d  = ADDR;
        end
      end
      ADDR: begin
        sram_addr_d  = fb_addr(pt_q);
        sram_wdata_d = color_q;
        if (clipped) begin
          state_d = IDLE;
        end else begin
          ce_n_d  = 1'b0;
          we_n_d  = 1'b0;
          cnt_d   = CNT_W'(WR_CYCLES - 1);
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (cnt_q == '0) begin
          state_d = RECOVER;
        end else begin
          ce_n_d = 1'b0;
          we_n_d = 1'b0;
          cnt_d  = cnt_q - 1'b1;
        end
      end
      RECOVER: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state and registered SRAM pins; reset aborts any write.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rdy_en_q     <= 1'b0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      we_n_q       <= 1'b1;
      ce_n_q       <= 1'b1;
    end else begin
      rdy_en_q     <= rdy_en_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      we_n_q       <= we_n_d;
      ce_n_q       <= ce_n_d;
    end
  end

  // Popped pixel holding register; only meaningful while in ADDR.
  always_ff @(posedge clk) begin
    pt_q    <= pt_d;
    color_q <= color_d;
  end

  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;
  assign sram_we_n  = we_n_q;
  assign sram_ce_n  = ce_n_q;
  assign busy       = ~fifo_empty | (state_q != IDLE);

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed testbench for fb_pixel_writer (default parameters).
// Honours FB_CLIP_EN when the bundle is built with that macro.
module tb_fb_pixel_writer;
  import fb_pixel_writer_pkg::*;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        in_valid;
  logic        in_ready;
  Point2D      in_pt;
  logic [15:0] in_color;
  logic [18:0] sram_addr;
  logic [15:0] sram_wdata;
  logic        sram_we_n;
  logic        sram_ce_n;
  logic        busy;
  logic [15:0] clip_cnt;

  int n_cmp = 0;
  int n_err = 0;

  fb_pixel_writer dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pt      (in_pt),
    .in_color   (in_color),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_we_n  (sram_we_n),
    .sram_ce_n  (sram_ce_n),
    .busy       (busy),
    .clip_cnt   (clip_cnt)
  );

  always #5 clk = ~clk;

  // Strobe monitor: records each we_n-low window sampled on the falling edge.
  int   cyc = 0;
  int   n_starts = 0;
  int   unstable = 0;
  bit   in_strobe = 1'b0;
  int   cur_addr, cur_data, cur_len, cur_start;
  int   wr_addr[$];
  int   wr_data[$];
  int   wr_len[$];
  int   wr_start[$];

  always @(negedge clk) begin
    cyc++;
    if (sram_we_n === 1'b0) begin
      if (!in_strobe) begin
        in_strobe = 1'b1;
        n_starts++;
        cur_addr  = int'(sram_addr);
        cur_data  = int'(sram_wdata);
        cur_len   = 1;
        cur_start = cyc;
        if (sram_ce_n !== 1'b0) unstable++;
      end else begin
        cur_len++;
        if (int'(sram_addr) != cur_addr || int'(sram_wdata) != cur_data || sram_ce_n !== 1'b0)
          unstable++;
      end
    end else if (in_strobe) begin
      in_strobe = 1'b0;
      wr_addr.push_back(cur_addr);
      wr_data.push_back(cur_data);
      wr_len.push_back(cur_len);
      wr_start.push_back(cur_start);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one pixel, waits (bounded) for in_ready, then takes the edge.
  // in_valid is left high so callers can chain pushes back-to-back.
  task automatic push_px(input int x, input int y, input logic [15:0] c);
    int k;
    in_pt.x  = shortint'(x);
    in_pt.y  = shortint'(y);
    in_color = c;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 100) begin
      step();
      k++;
    end
    if (k >= 100) chk("push_ready_timeout", int'(in_ready), 1);
    step();
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      step();
      k++;
    end
    if (k >= budget) chk("idle_timeout", int'(busy), 0);
  endtask

  function automatic int wa(input int i);
    return (i < wr_addr.size()) ? wr_addr[i] : -1;
  endfunction

  function automatic int wd(input int i);
    return (i < wr_data.size()) ? wr_data[i] : -1;
  endfunction

  function automatic int wl(input int i);
    return (i < wr_len.size()) ? wr_len[i] : -1;
  endfunction

  function automatic int ws(input int i);
    return (i < wr_start.size()) ? wr_start[i] : -1;
  endfunction

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int acc;
    int s0;

    // ---- reset state ----
    n_rst    = 1'b0;
    in_valid = 1'b0;
    in_pt    = '0;
    in_color = '0;
    repeat (3) step();
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_we_n", int'(sram_we_n), 1);
    chk("rst_ce_n", int'(sram_ce_n), 1);
    chk("rst_addr", int'(sram_addr), 0);
    chk("rst_wdata", int'(sram_wdata), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_clip_cnt", int'(clip_cnt), 0);
    n_rst = 1'b1;
    chk("ready_before_edge", int'(in_ready), 0);
    step();
    chk("ready_after_release", int'(in_ready), 1);

    // ---- single pixel (10,2): push at N, we_n falls at N+2 for 2 cycles ----
    base = wr_addr.size();
    push_px(10, 2, 16'hABCD);
    in_valid = 1'b0;
    chk("t1_busy_after_push", int'(busy), 1);
    chk("t1_we_n_n0", int'(sram_we_n), 1);
    step();
    chk("t1_we_n_n1", int'(sram_we_n), 1);
    step();
    chk("t1_we_n_n2", int'(sram_we_n), 0);
    chk("t1_ce_n_n2", int'(sram_ce_n), 0);
    chk("t1_addr", int'(sram_addr), 1290);
    chk("t1_wdata", int'(sram_wdata), 16'hABCD);
    step();
    chk("t1_we_n_n3", int'(sram_we_n), 0);
    step();
    chk("t1_we_n_recover", int'(sram_we_n), 1);
    chk("t1_ce_n_recover", int'(sram_ce_n), 1);
    chk("t1_busy_recover", int'(busy), 1);
    step();
    chk("t1_busy_after", int'(busy), 0);
    chk("t1_nwrites", wr_addr.size() - base, 1);
    chk("t1_strobe_len", wl(base), 2);

    // ---- burst of 12 with in_valid held high ----
    // First pop at N+1, next every 5 edges: 9 accepts leave 7 queued,
    // the 10th fills the FIFO.
    base = wr_addr.size();
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      push_px(3 * i + 1, i + 1, 16'h1000 + 16'(i));
      acc++;
      if (acc == 9)  chk("t2_ready_after_9", int'(in_ready), 1);
      if (acc == 10) chk("t2_ready_after_10", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    wait_idle(300);
    chk("t2_nwrites", wr_addr.size() - base, 12);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("t2_addr%0d", i), wa(base + i), (i + 1) * 640 + 3 * i + 1);
      chk($sformatf("t2_data%0d", i), wd(base + i), 32'h1000 + i);
      chk($sformatf("t2_len%0d", i), wl(base + i), 2);
      if (i > 0) chk($sformatf("t2_gap%0d", i), ws(base + i) - ws(base + i - 1), 5);
    end

`ifdef FB_CLIP_EN
    // ---- clipping: only (639,479) reaches the SRAM ----
    base = wr_addr.size();
    push_px(-1, 0, 16'h0001);
    push_px(640, 5, 16'h0002);
    push_px(3, 480, 16'h0003);
    push_px(639, 479, 16'h0004);
    in_valid = 1'b0;
    wait_idle(200);
    chk("t3_nwrites", wr_addr.size() - base, 1);
    chk("t3_addr", wa(base), 307199);
    chk("t3_data", wd(base), 4);
    chk("t3_clip_cnt", int'(clip_cnt), 3);
`else
    // ---- no clipping: (640,0) is written at address 640 ----
    base = wr_addr.size();
    push_px(640, 0, 16'h5A5A);
    in_valid = 1'b0;
    wait_idle(100);
    chk("t4_nwrites", wr_addr.size() - base, 1);
    chk("t4_addr", wa(base), 640);
    chk("t4_data", wd(base), 16'h5A5A);
    chk("t4_clip_cnt", int'(clip_cnt), 0);
`endif

    // ---- reset during WRITE with 3 pixels queued ----
    push_px(1, 1, 16'h0101);
    push_px(2, 1, 16'h0102);
    push_px(3, 1, 16'h0103);
    push_px(4, 1, 16'h0104);
    in_valid = 1'b0;
    chk("t5_in_write", int'(sram_we_n), 0);
    chk("t5_queued_busy", int'(busy), 1);
    n_rst = 1'b0;
    step();
    chk("t5_we_n_rst", int'(sram_we_n), 1);
    chk("t5_ce_n_rst", int'(sram_ce_n), 1);
    chk("t5_ready_rst", int'(in_ready), 0);
    chk("t5_busy_rst", int'(busy), 0);
    chk("t5_addr_rst", int'(sram_addr), 0);
    n_rst = 1'b1;
    s0 = n_starts;
    repeat (20) step();
    chk("t5_no_writes", n_starts - s0, 0);
    chk("t5_busy_after", int'(busy), 0);
    chk("t5_ready_after", int'(in_ready), 1);

    // ---- push coinciding with the IDLE pop of a single queued entry ----
    base = wr_addr.size();
    push_px(5, 5, 16'hAAAA);
    push_px(6, 5, 16'hBBBB);
    in_valid = 1'b0;
    wait_idle(100);
    chk("t6_nwrites", wr_addr.size() - base, 2);
    chk("t6_addr0", wa(base), 3205);
    chk("t6_data0", wd(base), 16'hAAAA);
    chk("t6_addr1", wa(base + 1), 3206);
    chk("t6_data1", wd(base + 1), 16'hBBBB);
    chk("t6_gap", ws(base + 1) - ws(base), 5);

    chk("strobe_stable", unstable, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
